// File: rtl/bor_por_puc.sv
// Reset-event generator at the head of the interrupt priority chain.
// Holds a reset request while RSTn is low or still settling, debounces the
// release, and latches the bootstrap-loader entry decision from TEST pin
// activity seen while RSTn was low. When idle, it passes the downstream
// vector index and the acknowledge straight through.
module bor_por_puc #(
  parameter logic [5:0] RESET_IDX = 6'h3F,
  parameter int         DEBOUNCE  = 8,
  parameter int         CNT_W     = 4
) (
  input  logic       MCLK,
  input  logic       rst,
  input  logic       RSTn,
  input  logic       TEST,
  input  logic       INTACKin,
  input  logic [5:0] IntAddrthru,
  output logic       req,
  output logic       INTACKthru,
  output logic       BSLenter,
  output logic [5:0] IntAddrout
);

  // Counter value on which the last required clean high sample arrives.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             rstn_q;
  logic             test_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       tcnt;

  logic rstn_rise;
  logic rstn_fall;
  logic test_rise;

  // Edge detection against the one-stage pin samples.
  always_comb begin
    rstn_rise = RSTn & ~rstn_q;
    rstn_fall = ~RSTn & rstn_q;
    test_rise = TEST & ~test_q;
  end

  // Pin samples: reset values make the first cycle look like RSTn high, TEST low.
  always_ff @(posedge MCLK) begin
    if (rst) begin
      rstn_q <= 1'b1;
      test_q <= 1'b0;
    end else begin
      rstn_q <= RSTn;
      test_q <= TEST;
    end
  end

  // Reset request and debounce: any low sample restarts the count, so req
  // releases only after DEBOUNCE consecutive high samples.
  always_ff @(posedge MCLK) begin
    if (rst) begin
      req <= 1'b1;
      cnt <= '0;
    end else if (!RSTn) begin
      req <= 1'b1;
      cnt <= '0;
    end else if (req) begin
      if (cnt == CNT_LAST) begin
        req <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // TEST rising-edge count while RSTn is held low; cleared when RSTn falls.
  always_ff @(posedge MCLK) begin
    if (rst) begin
      tcnt <= 2'd0;
    end else if (rstn_fall) begin
      tcnt <= 2'd0;
    end else if (!rstn_q && test_rise && (tcnt != 2'd2)) begin
      tcnt <= tcnt + 2'd1;
    end
  end

  // BSL decision at the RSTn rising edge; held until the next decision.
  always_ff @(posedge MCLK) begin
    if (rst) begin
      BSLenter <= 1'b0;
    end else if (rstn_rise) begin
      BSLenter <= (tcnt == 2'd2) && TEST;
    end
  end

  // Chain outputs: reset vector overrides lower-priority sources, and the
  // acknowledge is consumed here while the reset request is pending.
  always_comb begin
    IntAddrout = req ? RESET_IDX : IntAddrthru;
    INTACKthru = INTACKin & ~req;
  end

endmodule

// File: tb/tb_bor_por_puc.sv
// Directed bench for bor_por_puc: power-up release, idle feedthrough,
// reset during run, bounce, BSL entry and BSL reject sequences.
module tb_bor_por_puc;

  logic       MCLK = 1'b0;
  logic       rst;
  logic       RSTn;
  logic       TEST;
  logic       INTACKin;
  logic [5:0] IntAddrthru;
  logic       req;
  logic       INTACKthru;
  logic       BSLenter;
  logic [5:0] IntAddrout;

  int n_checks = 0;
  int n_pass   = 0;

  bor_por_puc #(
    .RESET_IDX(6'h3F),
    .DEBOUNCE (8),
    .CNT_W    (4)
  ) dut (
    .MCLK       (MCLK),
    .rst        (rst),
    .RSTn       (RSTn),
    .TEST       (TEST),
    .INTACKin   (INTACKin),
    .IntAddrthru(IntAddrthru),
    .req        (req),
    .INTACKthru (INTACKthru),
    .BSLenter   (BSLenter),
    .IntAddrout (IntAddrout)
  );

  always #5 MCLK = ~MCLK;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-14s observed=%0h expected=%0h", tag, obs, exp);
    end else begin
      $display("FAIL %-14s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  initial begin
    rst = 1'b1; RSTn = 1'b1; TEST = 1'b0; INTACKin = 1'b0; IntAddrthru = 6'h05;

    // 1. Power-up
    tick();
    check_eq("rst_req", req, 1);
    check_eq("rst_bsl", BSLenter, 0);
    check_eq("rst_addr", IntAddrout, 6'h3F);
    INTACKin = 1'b1; #1;
    check_eq("rst_ack", INTACKthru, 0);
    INTACKin = 1'b0;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("por_req", req, (i < 8) ? 1 : 0);
    end
    #1;
    check_eq("por_addr", IntAddrout, 6'h05);

    // 2. Idle feedthrough
    IntAddrthru = 6'h2A; #1;
    check_eq("thru_addr", IntAddrout, 6'h2A);
    INTACKin = 1'b1; #1;
    check_eq("thru_ack1", INTACKthru, 1);
    INTACKin = 1'b0; #1;
    check_eq("thru_ack0", INTACKthru, 0);
    IntAddrthru = 6'h11; #1;
    check_eq("thru_addr2", IntAddrout, 6'h11);

    // 3. Reset during run, acknowledge while req is high
    RSTn = 1'b0; #1;
    check_eq("run_req_pre", req, 0);
    tick();
    check_eq("run_req_set", req, 1);
    INTACKin = 1'b1; #1;
    check_eq("run_ack", INTACKthru, 0);
    check_eq("run_addr", IntAddrout, 6'h3F);
    INTACKin = 1'b0;
    tick(); tick();
    check_eq("run_req_low", req, 1);
    RSTn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      INTACKin = (i == 3);
      tick();
      check_eq("run_rel", req, (i < 8) ? 1 : 0);
    end
    INTACKin = 1'b0;
    check_eq("run_bsl", BSLenter, 0);

    // 4. Bounce train: low, then 1-cycle highs separated by lows
    for (int i = 0; i < 7; i++) begin
      RSTn = (i % 2 == 1);
      tick();
      check_eq("bnc_hold", req, 1);
    end
    RSTn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("bnc_rel", req, (i < 8) ? 1 : 0);
    end

    // 5. BSL entry: two TEST rises while RSTn low, TEST high at RSTn rise
    RSTn = 1'b0; TEST = 1'b0;
    tick(); tick(); tick();
    TEST = 1'b1; tick();
    TEST = 1'b0; tick();
    TEST = 1'b1; tick();
    check_eq("bsl_pre", BSLenter, 0);
    RSTn = 1'b1; tick();
    check_eq("bsl_set", BSLenter, 1);
    TEST = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_eq("bsl_rel", req, (i < 8) ? 1 : 0);
      check_eq("bsl_hold", BSLenter, 1);
    end

    // 6a. BSL reject: single TEST pulse, TEST low at RSTn rise
    RSTn = 1'b0; tick();
    TEST = 1'b1; tick();
    TEST = 1'b0; tick();
    check_eq("rej_pre", BSLenter, 1);
    RSTn = 1'b1; tick();
    check_eq("rej_clr", BSLenter, 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check_eq("rej_rel", req, (i < 8) ? 1 : 0);
    end

    // 6b. Short RSTn low pulse, TEST toggling only while RSTn high
    RSTn = 1'b0; tick();
    check_eq("rej2_req", req, 1);
    RSTn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      TEST = (i % 2 == 1);
      tick();
      check_eq("rej2_rel", req, (i < 8) ? 1 : 0);
      check_eq("rej2_bsl", BSLenter, 0);
    end
    TEST = 1'b0;

    // rst wins over a simultaneous low RSTn sample
    rst = 1'b1; RSTn = 1'b0; tick();
    check_eq("rst2_req", req, 1);
    rst = 1'b0; RSTn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check_eq("rst2_rel", req, (i < 8) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
